// File: rtl/out_fm_tile_ld_mask.sv
`default_nettype none
// ============================================================================
// Module   : out_fm_tile_ld_mask
// Purpose  : Filters the DRAM read stream of one out_fm tile: discards row
//            padding and zero-fills or drops words outside the layer bounds.
// Revision : 1.0 - initial release
// ============================================================================
module out_fm_tile_ld_mask #(
    parameter int DW              = 32,
    parameter int CW              = 16,
    parameter int Tn              = 16,
    parameter int Tr              = 64,
    parameter int Tc              = 16,
    parameter int TILE_ROW_OFFSET = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] cfg_n,
    input  logic [CW-1:0] cfg_r,
    input  logic [CW-1:0] cfg_c,
    input  logic          cfg_drop,
    input  logic [CW-1:0] tile_base_n,
    input  logic [CW-1:0] tile_base_row,
    input  logic [CW-1:0] tile_base_col,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] out_cnt
);

    localparam logic [CW-1:0] c_TC_VALID = CW'(Tc);
    localparam logic [CW-1:0] c_TC_LAST  = CW'(Tc + TILE_ROW_OFFSET - 1);
    localparam logic [CW-1:0] c_TR_LAST  = CW'(Tr - 1);
    localparam logic [CW-1:0] c_TN_LAST  = CW'(Tn - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tc_q, tc_d, tr_q, tr_d, tn_q, tn_d;
    logic [CW-1:0] cfg_n_q, cfg_n_d, cfg_r_q, cfg_r_d, cfg_c_q, cfg_c_d;
    logic          cfg_drop_q, cfg_drop_d;
    logic [CW-1:0] base_n_q, base_n_d, base_row_q, base_row_d, base_col_q, base_col_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          done_q, done_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    logic          w_in_ready, w_accept, w_out_hs, w_pad, w_inb, w_load, w_last_beat;
    logic [CW:0]   w_sum_n, w_sum_row, w_sum_col;

    // One extra bit on the sums so a base near the top of the range never wraps into bounds.
    assign w_sum_n     = {1'b0, base_n_q}   + {1'b0, tn_q};
    assign w_sum_row   = {1'b0, base_row_q} + {1'b0, tr_q};
    assign w_sum_col   = {1'b0, base_col_q} + {1'b0, tc_q};
    assign w_inb       = (w_sum_n < {1'b0, cfg_n_q}) && (w_sum_row < {1'b0, cfg_r_q})
                      && (w_sum_col < {1'b0, cfg_c_q});
    assign w_pad       = (tc_q >= c_TC_VALID);
    assign w_in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_out_hs    = out_valid_q && out_ready;
    assign w_load      = w_accept && !w_pad && (w_inb || !cfg_drop_q);
    assign w_last_beat = (tc_q == c_TC_LAST) && (tr_q == c_TR_LAST) && (tn_q == c_TN_LAST);

    always_comb begin
        state_d     = state_q;
        tc_d        = tc_q;
        tr_d        = tr_q;
        tn_d        = tn_q;
        cfg_n_d     = cfg_n_q;
        cfg_r_d     = cfg_r_q;
        cfg_c_d     = cfg_c_q;
        cfg_drop_d  = cfg_drop_q;
        base_n_d    = base_n_q;
        base_row_d  = base_row_q;
        base_col_d  = base_col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        done_d      = 1'b0;

        // A handshake empties the register unless a new word lands in the same cycle.
        if (w_out_hs) begin
            out_valid_d = 1'b0;
            out_cnt_d   = out_cnt_q + 1'b1;
        end
        if (w_load) begin
            out_valid_d = 1'b1;
            out_data_d  = w_inb ? in_data : '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    tc_d       = '0;
                    tr_d       = '0;
                    tn_d       = '0;
                    out_cnt_d  = '0;
                    cfg_n_d    = cfg_n;
                    cfg_r_d    = cfg_r;
                    cfg_c_d    = cfg_c;
                    cfg_drop_d = cfg_drop;
                    base_n_d   = tile_base_n;
                    base_row_d = tile_base_row;
                    base_col_d = tile_base_col;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    if (tc_q == c_TC_LAST) begin
                        tc_d = '0;
                        if (tr_q == c_TR_LAST) begin
                            tr_d = '0;
                            tn_d = (tn_q == c_TN_LAST) ? '0 : tn_q + 1'b1;
                        end else begin
                            tr_d = tr_q + 1'b1;
                        end
                    end else begin
                        tc_d = tc_q + 1'b1;
                    end
                    if (w_last_beat) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tc_q        <= '0;
            tr_q        <= '0;
            tn_q        <= '0;
            cfg_n_q     <= '0;
            cfg_r_q     <= '0;
            cfg_c_q     <= '0;
            cfg_drop_q  <= 1'b0;
            base_n_q    <= '0;
            base_row_q  <= '0;
            base_col_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tc_q        <= tc_d;
            tr_q        <= tr_d;
            tn_q        <= tn_d;
            cfg_n_q     <= cfg_n_d;
            cfg_r_q     <= cfg_r_d;
            cfg_c_q     <= cfg_c_d;
            cfg_drop_q  <= cfg_drop_d;
            base_n_q    <= base_n_d;
            base_row_q  <= base_row_d;
            base_col_q  <= base_col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_cnt   = out_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_out_fm_tile_ld_mask.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_fm_tile_ld_mask
// Purpose  : Directed self-checking bench for out_fm_tile_ld_mask on a small
//            2x2x(4+2) tile.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_out_fm_tile_ld_mask;

    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int TN    = 2;
    localparam int TR    = 2;
    localparam int TC    = 4;
    localparam int OFF   = 2;
    localparam int ROWW  = TC + OFF;
    localparam int TOTAL = TN * TR * ROWW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] cfg_n, cfg_r, cfg_c;
    logic          cfg_drop;
    logic [CW-1:0] tile_base_n, tile_base_row, tile_base_col;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] out_cnt;

    out_fm_tile_ld_mask #(
        .DW(DW), .CW(CW), .Tn(TN), .Tr(TR), .Tc(TC), .TILE_ROW_OFFSET(OFF)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_n(cfg_n), .cfg_r(cfg_r), .cfg_c(cfg_c), .cfg_drop(cfg_drop),
        .tile_base_n(tile_base_n), .tile_base_row(tile_base_row), .tile_base_col(tile_base_col),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];
    int            done_cnt, stall_err, rdy_err, last_acc_cyc, done_cyc;
    bit            timed_out;
    logic          nxt_valid[TOTAL];
    logic [DW-1:0] nxt_data[TOTAL];

    // -1 when identical, -2 on length difference, else first differing index.
    function automatic int first_diff();
        if (got.size() != exp_q.size()) return -2;
        foreach (got[i]) if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic pulse_start(input int n, input int r, input int c, input bit drop,
                               input int bn, input int brow, input int bcol);
        @(posedge clk); #1;
        cfg_n = CW'(n); cfg_r = CW'(r); cfg_c = CW'(c); cfg_drop = drop;
        tile_base_n = CW'(bn); tile_base_row = CW'(brow); tile_base_col = CW'(bcol);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams beats 1..TOTAL, records handshaken outputs, stall and latency observations.
    task automatic run_tile(input bit bp, input int start_at);
        int            b = 0, cyc = 0, extra = 0, pend = -1;
        bit            acc, prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        got.delete();
        done_cnt = 0; stall_err = 0; rdy_err = 0;
        last_acc_cyc = -1; done_cyc = -1; timed_out = 1'b0;
        in_valid = 1'b1; in_data = 1;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        while (extra < 3) begin
            if (cyc >= 2000) begin timed_out = 1'b1; break; end
            @(negedge clk);
            if (pend >= 0) begin nxt_valid[pend] = out_valid; nxt_data[pend] = out_data; pend = -1; end
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_err++;
            if (out_valid && !out_ready && in_ready) rdy_err++;
            if (done === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (out_valid && out_ready) got.push_back(out_data);
            acc        = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk); #1;
            cyc++;
            if (done_cnt > 0) extra++;
            if (acc) begin pend = b; b++; last_acc_cyc = cyc; end
            start = (cyc == start_at);
            if (start) cfg_c = '0;
            in_valid = (b < TOTAL);
            in_data  = DW'(b + 1);
            if (bp) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    endtask

    task automatic build_interior();
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) if ((i % ROWW) < TC) exp_q.push_back(DW'(i + 1));
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, in_ready, busy, done} !== 4'b0 || out_data !== '0 || out_cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b rdy=%b busy=%b done=%b data=%h cnt=%0d, required all 0",
                     out_valid, in_ready, busy, done, out_data, out_cnt);
        end
    endtask

    task automatic test_interior();
        int d;
        pulse_start(64, 64, 64, 1'b0, 0, 0, 0);
        run_tile(1'b0, -1);
        build_interior();
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL interior_words: got %0d words (diff %0d), required %0d", got.size(), d, exp_q.size()); end
        checks++;
        if (out_cnt !== 16) begin errors++; $display("FAIL interior_cnt: got %0d, required 16", out_cnt); end
        checks++;
        if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL interior_done: got %0d pulses (timeout %0d), required 1", done_cnt, timed_out); end
        checks++;
        if (nxt_valid[0] !== 1'b1 || nxt_data[0] !== 1 || nxt_data[3] !== 4) begin
            errors++;
            $display("FAIL interior_latency: got v=%b d0=%0d d3=%0d, required v=1 d0=1 d3=4", nxt_valid[0], nxt_data[0], nxt_data[3]);
        end
        checks++;
        if (done_cyc - last_acc_cyc != 1) begin errors++; $display("FAIL interior_done_time: got %0d cycles after last beat, required 1", done_cyc - last_acc_cyc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL interior_busy: got %b, required 0", busy); end
    endtask

    task automatic test_col_edge_zero();
        int d;
        pulse_start(64, 64, 6, 1'b0, 0, 0, 4);
        run_tile(1'b0, -1);
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) begin
            if ((i % ROWW) < 2) exp_q.push_back(DW'(i + 1));
            else if ((i % ROWW) < TC) exp_q.push_back('0);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL col_zero_words: got %0d words (diff %0d), required %0d", got.size(), d, exp_q.size()); end
        checks++;
        if (out_cnt !== 16 || done_cnt != 1) begin errors++; $display("FAIL col_zero_cnt: got cnt=%0d done=%0d, required 16 and 1", out_cnt, done_cnt); end
    endtask

    task automatic test_col_edge_drop();
        int d;
        pulse_start(64, 64, 6, 1'b1, 0, 0, 4);
        run_tile(1'b0, -1);
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) if ((i % ROWW) < 2) exp_q.push_back(DW'(i + 1));
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL col_drop_words: got %0d words (diff %0d), required %0d", got.size(), d, exp_q.size()); end
        checks++;
        if (out_cnt !== 8 || done_cnt != 1) begin errors++; $display("FAIL col_drop_cnt: got cnt=%0d done=%0d, required 8 and 1", out_cnt, done_cnt); end
        checks++;
        if (done_cyc - last_acc_cyc != 1) begin errors++; $display("FAIL col_drop_done_time: got %0d cycles after last beat, required 1", done_cyc - last_acc_cyc); end
    endtask

    task automatic test_chan_edge();
        int d;
        pulse_start(17, 64, 64, 1'b0, 16, 0, 0);
        run_tile(1'b0, -1);
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) begin
            if ((i % ROWW) < TC) exp_q.push_back((i < TR * ROWW) ? DW'(i + 1) : '0);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL chan_zero_words: got %0d words (diff %0d), required %0d", got.size(), d, exp_q.size()); end
        pulse_start(17, 64, 64, 1'b1, 16, 0, 0);
        run_tile(1'b0, -1);
        exp_q.delete();
        for (int i = 0; i < TR * ROWW; i++) if ((i % ROWW) < TC) exp_q.push_back(DW'(i + 1));
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL chan_drop_words: got %0d words (diff %0d), required %0d", got.size(), d, exp_q.size()); end
        checks++;
        if (out_cnt !== TR * TC) begin errors++; $display("FAIL chan_drop_cnt: got %0d, required %0d", out_cnt, TR * TC); end
    endtask

    task automatic test_backpressure();
        int d;
        pulse_start(64, 64, 64, 1'b0, 0, 0, 0);
        run_tile(1'b1, -1);
        build_interior();
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL bp_words: got %0d words (diff %0d), required %0d", got.size(), d, exp_q.size()); end
        checks++;
        if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes while stalled, required 0", stall_err); end
        checks++;
        if (rdy_err != 0) begin errors++; $display("FAIL bp_in_ready: got %0d cycles ready while stalled, required 0", rdy_err); end
        checks++;
        if (out_cnt !== 16 || done_cnt != 1) begin errors++; $display("FAIL bp_cnt: got cnt=%0d done=%0d, required 16 and 1", out_cnt, done_cnt); end
    endtask

    task automatic test_start_ignored();
        int d;
        pulse_start(64, 64, 64, 1'b0, 0, 0, 0);
        run_tile(1'b0, 5);
        build_interior();
        d = first_diff();
        checks++;
        if (d != -1 || out_cnt !== 16) begin
            errors++;
            $display("FAIL start_ignored: got %0d words cnt=%0d (diff %0d), required 16 words", got.size(), out_cnt, d);
        end
    endtask

    task automatic test_reset_mid_run();
        int stray = 0;
        int d;
        pulse_start(64, 64, 64, 1'b0, 0, 0, 0);
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hA5) begin
            errors++;
            $display("FAIL mid_run_state: got busy=%b v=%b data=%h, required 1 1 a5", busy, out_valid, out_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, busy, done} !== 4'b0 || out_data !== '0 || out_cnt !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: got v=%b rdy=%b busy=%b done=%b data=%h cnt=%0d, required all 0",
                     out_valid, in_ready, busy, done, out_data, out_cnt);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL mid_run_no_done: got %0d done pulses, required 0", stray); end
        pulse_start(64, 64, 64, 1'b0, 0, 0, 0);
        run_tile(1'b0, -1);
        build_interior();
        d = first_diff();
        checks++;
        if (d != -1 || out_cnt !== 16 || done_cnt != 1) begin
            errors++;
            $display("FAIL post_reset_tile: got %0d words cnt=%0d done=%0d (diff %0d), required 16 16 1",
                     got.size(), out_cnt, done_cnt, d);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_n = '0; cfg_r = '0; cfg_c = '0; cfg_drop = 1'b0;
        tile_base_n = '0; tile_base_row = '0; tile_base_col = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_interior();
        test_col_edge_zero();
        test_col_edge_drop();
        test_chan_edge();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
